// File: rtl/result_display_ctrl.sv
// result_display_ctrl: button-selected result word shown in decimal on six active-low seven-segment digits
module result_display_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] result_suma,
    input  logic [DATA_W-1:0] result_resta,
    input  logic [DATA_W-1:0] result_mult,
    input  logic [DATA_W-1:0] result_div,
    input  logic [DATA_W-1:0] result_pow,
    input  logic              btn_next_n,
    output logic [2:0]        sel_op,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW  = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t            r_state;
    logic [1:0]        r_sync;
    logic              r_btn_acc;
    logic [DBW-1:0]    r_db_cnt;
    logic              r_press;
    logic [2:0]        r_sel;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_snap;
    logic [DATA_W-1:0] r_shown_val;
    logic [2:0]        r_snap_sel;
    logic [2:0]        r_shown_sel;
    logic              r_shown_valid;
    logic [39:0]       r_bcd;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_ovf;
    logic [6:0]        r_hex [6];
    logic [DATA_W-1:0] w_cur;
    logic [39:0]       w_bcd_adj;
    logic [6:0]        w_hex [6];
    logic              w_ovf;
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction
    assign w_cur = (r_sel == 3'd1) ? result_resta :
                   (r_sel == 3'd2) ? result_mult  :
                   (r_sel == 3'd3) ? result_div   :
                   (r_sel == 3'd4) ? result_pow   : result_suma;
    // two-flop synchronizer for the raw button; idles released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], btn_next_n};
    end
    // accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles; falling edge is a press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_acc <= 1'b1;
            r_db_cnt  <= '0;
            r_press   <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync[1] == r_btn_acc) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                r_btn_acc <= r_sync[1];
                r_db_cnt  <= '0;
                r_press   <= ~r_sync[1];
            end else begin
                r_db_cnt <= r_db_cnt + DBW'(1);
            end
        end
    end
    // each press steps through the five results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_sel <= 3'd0;
        else if (r_press) r_sel <= (r_sel == 3'd4) ? 3'd0 : r_sel + 3'd1;
    end
    // double-dabble correction: any BCD digit of 5 or more gets +3 before the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 10; i++)
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    // finished BCD to segments: dashes past six digits, leading zeros blanked, units digit always lit
    always_comb begin
        logic w_seen;
        w_ovf  = |r_bcd[39:24];
        w_seen = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            w_seen   = w_seen | (r_bcd[4*i +: 4] != 4'd0) | (i == 0);
            w_hex[i] = w_ovf ? 7'h3F : w_seen ? seg7(r_bcd[4*i +: 4]) : 7'h7F;
        end
    end
    // conversion sequencer; a changed input mid-run is caught by the IDLE compare afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_ovf         <= 1'b0;
            r_shown_valid <= 1'b0;
            r_shown_val   <= '0;
            r_shown_sel   <= 3'd0;
            r_shift       <= '0;
            r_snap        <= '0;
            r_snap_sel    <= 3'd0;
            r_bcd         <= '0;
            r_cnt         <= '0;
            for (int i = 0; i < 6; i++) r_hex[i] <= 7'h7F;
        end else begin
            case (r_state)
                IDLE: if (!r_shown_valid || w_cur != r_shown_val || r_sel != r_shown_sel) begin
                    r_state <= LOAD;
                    r_busy  <= 1'b1;
                end
                LOAD: begin
                    r_shift    <= w_cur;
                    r_snap     <= w_cur;
                    r_snap_sel <= r_sel;
                    r_bcd      <= '0;
                    r_cnt      <= '0;
                    r_state    <= SHIFT;
                end
                SHIFT: begin
                    {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                    r_cnt            <= r_cnt + CW'(1);
                    if (r_cnt == CW'(DATA_W - 1)) r_state <= DONE;
                end
                DONE: begin
                    r_shown_val   <= r_snap;
                    r_shown_sel   <= r_snap_sel;
                    r_shown_valid <= 1'b1;
                    r_ovf         <= w_ovf;
                    for (int i = 0; i < 6; i++) r_hex[i] <= w_hex[i];
                    r_busy        <= 1'b0;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign sel_op = r_sel;
    assign busy   = r_busy;
    assign ovf    = r_ovf;
    assign hex0   = r_hex[0];
    assign hex1   = r_hex[1];
    assign hex2   = r_hex[2];
    assign hex3   = r_hex[3];
    assign hex4   = r_hex[4];
    assign hex5   = r_hex[5];
endmodule
